soc_mode_ctrl: RTL
==================

# soc_mode_ctrl

Top-level sequencing controller for the SoC image pipeline. It samples the START, mode and buzzer switches. It runs the Sobel row processor over BRAM one row at a time (mode 2), or goes straight to display (mode 1). It then enables VGA output and drives the status LEDs and a buzzer trigger. It sits between the board switch inputs and the row processor, VGA and buzzer blocks inside the top-level SoC.

## Interface
- IMG_ROWS, 480: number of image rows per frame; must be between 2 and 1023.
- TIMEOUT, 65535: maximum number of cycles to wait for row_done_i per row; 16-bit counter.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- MODE1_START_I  in  1  mode-1 switch, asynchronous to clk.
- MODE2_START_I  in  1  mode-2 switch, asynchronous to clk.
- START_I  in  1  start button, asynchronous to clk.
- BUZZER_MODE_I  in  1  buzzer enable switch, asynchronous to clk.
- row_done_i  in  1  single-cycle pulse from the row processor when the current row is complete.
- row_start_o  out  1  single-cycle request to process row row_idx_o.
- row_idx_o  out  10  current row index, also exported as cnt_img_row.
- proc_mode_o  out  2  latched mode: 0 = none, 1 = raw, 2 = Sobel.
- vga_en_o  out  1  enables VGA output.
- LED1_ON_o  out  1  high when the latched mode is 1 and the controller is not idle.
- LED2_ON_o  out  1  high when the latched mode is 2 and the controller is not idle.
- LED_IDLE_O  out  1  high when the controller is in IDLE.
- buzzer_trig_o  out  1  single-cycle pulse on frame completion.
- err_o  out  1  single-cycle pulse on an invalid start or a row timeout.

## Operation
- **Input synchronisation:** each of the four switch inputs passes through a 2-flop synchroniser.
- **Start detection:** START_I uses a third flop. start_pulse = s2 & ~s3.
- **Mode decode at start_pulse:**
  - MODE1 = 1 and MODE2 = 0 → mode 1.
  - MODE1 = 0 and MODE2 = 1 → mode 2.
  - Any other combination → invalid: err_o pulses and the state is unchanged.
- **States:** IDLE, ISSUE, WAIT, DISPLAY. All outputs are registered.
- **IDLE:**
  - Valid start, mode 1 → latch proc_mode_o = 1, go to DISPLAY.
  - Valid start, mode 2 → latch proc_mode_o = 2, set row_idx_o = 0, go to ISSUE.
- **ISSUE:** row_start_o = 1 for exactly one cycle, clear the timeout counter, then go to WAIT.
- **WAIT:** the timeout counter increments every cycle.
  - row_done_i with row_idx_o == IMG_ROWS-1 → go to DISPLAY.
  - row_done_i otherwise → increment row_idx_o, go to ISSUE.
  - Counter reaches TIMEOUT without row_done_i → err_o pulses, go to IDLE, proc_mode_o = 0.
  - If row_done_i and the timeout occur in the same cycle, row_done_i wins.
- **DISPLAY:**
  - vga_en_o = 1.
  - On entry, buzzer_trig_o pulses for one cycle, but only if the synchronised BUZZER_MODE_I is 1.
  - The controller stays here until a start_pulse arrives, which is decoded exactly as in IDLE (a restart).
  - vga_en_o drops in the same cycle ISSUE is entered.
- **Start while busy:** start_pulse in ISSUE or WAIT is ignored, with no err_o.
- **Stray row_done:** row_done_i outside WAIT is ignored.
- **Row counter:** row_idx_o never exceeds IMG_ROWS-1 and never wraps. It holds its last value in DISPLAY and resets to 0 on a mode-2 start.

## Timing
- **Reset values:**
  - LED_IDLE_O = 1.
  - All other outputs = 0, including row_idx_o = 0 and proc_mode_o = 0.
  - State = IDLE, synchroniser flops = 0.
- **Reset mid-operation:** takes effect immediately, aborts any row in flight, and drops vga_en_o at once.
- **Start latency:** START_I is first sampled high at edge k, so start_pulse is high in the cycle after edge k+1.
  - The state changes at edge k+2.
  - row_start_o or vga_en_o is high in the cycle after edge k+2.
- **Row handshake:**
  - row_done_i sampled at edge n → next row_start_o is high after edge n+1. The per-row overhead is 2 cycles beyond the processor's latency.
  - row_done_i for the last row sampled at edge n → vga_en_o and buzzer_trig_o are high after edge n.
- **Timeout:** fires when the counter equals TIMEOUT, i.e. TIMEOUT+1 cycles after row_start_o.
- **Single-cycle outputs:** row_start_o, buzzer_trig_o and err_o are each exactly one cycle wide.

## Test plan
- **Reset:** rst = 1 with random switch inputs → LED_IDLE_O = 1, all other outputs 0. Release rst → outputs unchanged.
- **Mode 1:** MODE1 = 1, START pulse 2 cycles wide, BUZZER = 1 → vga_en_o rises 3 edges after START, buzzer_trig_o pulses once, row_start_o never asserts, LED1_ON_o = 1.
- **Mode 2, full frame:** IMG_ROWS = 4, processor model replies 5 cycles after each request → row_start_o at row_idx 0,1,2,3 with spacing 7 cycles, then vga_en_o = 1. Extra START pulses mid-frame are ignored.
- **Invalid start:** both mode switches = 1, START → err_o pulses once, LED_IDLE_O stays 1. Then MODE2 only, START → run begins.
- **Timeout:** TIMEOUT = 10, no row_done_i → err_o TIMEOUT+1 cycles after row_start_o, state IDLE, proc_mode_o = 0.
- **Restart and mid-run reset:** restart from DISPLAY with MODE2 → row_idx_o back to 0 and vga_en_o = 0. Assert rst during WAIT at row 2 → immediate reset values; no row_start_o after release until a new START.

Source files
------------

// File: rtl/soc_mode_ctrl_if.sv
// Row-processor handshake: the controller requests a row with a one-cycle
// row_start_o and waits for the processor's one-cycle row_done_i.
interface soc_mode_ctrl_if;
  // row_start_o is a single-cycle request for row row_idx_o; the processor
  // replies later with a single-cycle row_done_i. There is no back-pressure.
  logic       row_start_o;
  logic [9:0] row_idx_o;
  logic       row_done_i;

  modport master (output row_start_o, output row_idx_o, input row_done_i);
  modport slave  (input row_start_o, input row_idx_o, output row_done_i);
endinterface

// File: rtl/soc_mode_ctrl.sv
// Frame sequencer: syncs the board switches, runs the row processor one row
// at a time in Sobel mode (or goes straight to display in raw mode).
module soc_mode_ctrl #(
  parameter int IMG_ROWS = 480,
  parameter int TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MODE1_START_I,
  input  logic                  MODE2_START_I,
  input  logic                  START_I,
  input  logic                  BUZZER_MODE_I,
  soc_mode_ctrl_if.master       row_if,
  output logic [1:0]            proc_mode_o,
  output logic                  vga_en_o,
  output logic                  LED1_ON_o,
  output logic                  LED2_ON_o,
  output logic                  LED_IDLE_O,
  output logic                  buzzer_trig_o,
  output logic                  err_o,
  output logic [9:0]            cnt_img_row,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  localparam logic [9:0]  LAST_ROW = 10'(IMG_ROWS - 1);
  localparam logic [15:0] TMO      = 16'(TIMEOUT);

  // Switch bits: [0] mode1, [1] mode2, [2] start, [3] buzzer
  logic [3:0]  sync1, sync2;
  logic        start_s3;
  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [1:0]  mode_n;
  logic [9:0]  idx_n;
  logic        row_start_n, err_n, buz_n;
  logic        m1, m2, bz, start_pulse, go_raw, go_sobel;

  assign m1          = sync2[0];
  assign m2          = sync2[1];
  assign bz          = sync2[3];
  assign start_pulse = sync2[2] & ~start_s3;
  assign go_raw      = m1 & ~m2;
  assign go_sobel    = ~m1 & m2;
  assign cnt_img_row = row_if.row_idx_o;
  assign state_dbg   = state_q;

  always_comb begin
    state_n = state_q;
    mode_n  = proc_mode_o;
    idx_n   = row_if.row_idx_o;
    err_n   = 1'b0;
    buz_n   = 1'b0;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE, DISPLAY: begin
        if (start_pulse) begin
          if (go_raw) begin
            state_n = DISPLAY;
            mode_n  = 2'd1;
            buz_n   = bz;
          end else if (go_sobel) begin
            state_n = ISSUE;
            mode_n  = 2'd2;
            idx_n   = 10'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = cnt_q + 16'd1;
      end
      WAIT: begin
        cnt_n = cnt_q + 16'd1;
        if (row_if.row_done_i) begin
          if (row_if.row_idx_o == LAST_ROW) begin
            state_n = DISPLAY;
            buz_n   = bz;
          end else begin
            state_n = ISSUE;
            idx_n   = row_if.row_idx_o + 10'd1;
          end
        end else if (cnt_q == TMO) begin
          state_n = IDLE;
          mode_n  = 2'd0;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // The first row is requested on entry to ISSUE; later rows are requested
    // as ISSUE is left, which yields the two-cycle per-row overhead.
    if (state_q == ISSUE)
      row_start_n = ~row_if.row_start_o;
    else
      row_start_n = (state_n == ISSUE) && (state_q != WAIT);

    // Timeout counts from the cycle the request is visible.
    if (row_start_n)
      cnt_n = 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1              <= 4'd0;
      sync2              <= 4'd0;
      start_s3           <= 1'b0;
      state_q            <= IDLE;
      cnt_q              <= 16'd0;
      row_if.row_start_o <= 1'b0;
      row_if.row_idx_o   <= 10'd0;
      proc_mode_o        <= 2'd0;
      vga_en_o           <= 1'b0;
      LED1_ON_o          <= 1'b0;
      LED2_ON_o          <= 1'b0;
      LED_IDLE_O         <= 1'b1;
      buzzer_trig_o      <= 1'b0;
      err_o              <= 1'b0;
    end else begin
      sync1              <= {BUZZER_MODE_I, START_I, MODE2_START_I, MODE1_START_I};
      sync2              <= sync1;
      start_s3           <= sync2[2];
      state_q            <= state_n;
      cnt_q              <= cnt_n;
      row_if.row_start_o <= row_start_n;
      row_if.row_idx_o   <= idx_n;
      proc_mode_o        <= mode_n;
      vga_en_o           <= (state_n == DISPLAY);
      LED1_ON_o          <= (mode_n == 2'd1) && (state_n != IDLE);
      LED2_ON_o          <= (mode_n == 2'd2) && (state_n != IDLE);
      LED_IDLE_O         <= (state_n == IDLE);
      buzzer_trig_o      <= buz_n;
      err_o              <= err_n;
    end
  end

endmodule
